// File: rtl/pc_target_unit.sv
// Fetch-stage program counter with a runtime-writable table of relative/absolute branch targets.
// Defining PC_LINK_EN adds Call/Ret inputs and a LinkReg output for single-level call/return.
module pc_target_unit #(
    parameter int D      = 12,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stall,
    input  logic              BranchEn,
    input  logic [ADDR_W-1:0] LutAddr,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [D-1:0]      WrData,
    input  logic              WrAbs,
`ifdef PC_LINK_EN
    input  logic              Call,
    input  logic              Ret,
    output logic [D-1:0]      LinkReg,
`endif
    output logic [D-1:0]      Target,
    output logic [D-1:0]      ProgCtr,
    output logic              BranchTaken
);

    logic [D-1:0]     val_q [DEPTH];
    logic [DEPTH-1:0] abs_q;
    logic [D-1:0]     pc_q, pc_d;
    logic             taken_q, taken_d;
    logic             lut_hit, wr_hit;

    assign lut_hit = int'(LutAddr) < DEPTH;
    assign wr_hit  = int'(WrAddr) < DEPTH;

    // Out-of-range table index yields the current PC, so the branch holds.
    always_comb begin
        Target = pc_q;
        if (lut_hit) begin
            if (abs_q[LutAddr]) begin
                Target = val_q[LutAddr];
            end else begin
                Target = pc_q + val_q[LutAddr];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                val_q[i] <= '0;
            end
            abs_q <= '0;
        end else if (WrEn && wr_hit) begin
            val_q[WrAddr] <= WrData;
            abs_q[WrAddr] <= WrAbs;
        end
    end

`ifdef PC_LINK_EN
    logic [D-1:0] link_q, link_d;
`endif

    always_comb begin
        pc_d    = pc_q + D'(1);
        taken_d = 1'b0;
`ifdef PC_LINK_EN
        link_d  = link_q;
`endif
        if (Start) begin
            pc_d = '0;
        end else if (Stall) begin
            pc_d = pc_q;
`ifdef PC_LINK_EN
        end else if (Ret) begin
            pc_d    = link_q;
            taken_d = 1'b1;
`endif
        end else if (BranchEn) begin
            pc_d    = Target;
            taken_d = 1'b1;
`ifdef PC_LINK_EN
            if (Call) begin
                link_d = pc_q + D'(1);
            end
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q    <= '0;
            taken_q <= 1'b0;
`ifdef PC_LINK_EN
            link_q  <= '0;
`endif
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
`ifdef PC_LINK_EN
            link_q  <= link_d;
`endif
        end
    end

    assign ProgCtr     = pc_q;
    assign BranchTaken = taken_q;
`ifdef PC_LINK_EN
    assign LinkReg     = link_q;
`endif

endmodule

// File: tb/tb_pc_target_unit.sv
// Scoreboard bench for pc_target_unit; built with PC_LINK_EN it also exercises call/return.
module tb_pc_target_unit;
    localparam int D     = 12;
    localparam int AW    = 3;
    localparam int DEPTH = 6;

    logic          Clk = 1'b0;
    logic          Reset, Start, Stall, BranchEn, WrEn, WrAbs;
    logic [AW-1:0] LutAddr, WrAddr;
    logic [D-1:0]  WrData, Target, ProgCtr;
    logic          BranchTaken;
`ifdef PC_LINK_EN
    logic          Call, Ret;
    logic [D-1:0]  LinkReg;
`endif

    always #5 Clk = ~Clk;

    pc_target_unit #(.D(D), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .BranchEn(BranchEn), .LutAddr(LutAddr), .WrEn(WrEn), .WrAddr(WrAddr),
        .WrData(WrData), .WrAbs(WrAbs),
`ifdef PC_LINK_EN
        .Call(Call), .Ret(Ret), .LinkReg(LinkReg),
`endif
        .Target(Target), .ProgCtr(ProgCtr), .BranchTaken(BranchTaken)
    );

    typedef struct {
        logic [D-1:0] pc;
        logic         taken;
        logic [D-1:0] link;
    } exp_t;

    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    logic [D-1:0] m_pc   = '0;
    logic [D-1:0] m_link = '0;
    logic [D-1:0] m_val [2**AW];
    logic         m_abs [2**AW];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [D-1:0] model_target(input logic [AW-1:0] a);
        if (int'(a) >= DEPTH) return m_pc;
        if (m_abs[a]) return m_val[a];
        return m_pc + m_val[a];
    endfunction

    task automatic clear_inputs();
        Reset = 0; Start = 0; Stall = 0; BranchEn = 0; WrEn = 0; WrAbs = 0;
        LutAddr = '0; WrAddr = '0; WrData = '0;
`ifdef PC_LINK_EN
        Call = 0; Ret = 0;
`endif
    endtask

    // Apply the currently driven inputs for one clock and score the result.
    task automatic step();
        exp_t         e;
        logic [D-1:0] tgt;
        #1;
        tgt = model_target(LutAddr);
        if (!Reset) check("target", Target, tgt);
        e.pc = m_pc + 1'b1; e.taken = 0; e.link = m_link;
        if (Reset) begin
            e.pc = '0; e.link = '0;
            for (int i = 0; i < 2**AW; i++) begin m_val[i] = '0; m_abs[i] = 0; end
        end else begin
            if (Start) e.pc = '0;
            else if (Stall) e.pc = m_pc;
`ifdef PC_LINK_EN
            else if (Ret) begin e.pc = m_link; e.taken = 1; end
`endif
            else if (BranchEn) begin
                e.pc = tgt; e.taken = 1;
`ifdef PC_LINK_EN
                if (Call) e.link = m_pc + 1'b1;
`endif
            end
            if (WrEn && int'(WrAddr) < DEPTH) begin
                m_val[WrAddr] = WrData; m_abs[WrAddr] = WrAbs;
            end
        end
        sb.push_back(e);
        @(posedge Clk); #1;
        e = sb.pop_front();
        check("ProgCtr", ProgCtr, e.pc);
        check("BranchTaken", BranchTaken, e.taken);
`ifdef PC_LINK_EN
        check("LinkReg", LinkReg, e.link);
`endif
        m_pc = e.pc; m_link = e.link;
    endtask

    task automatic idle();
        clear_inputs(); step();
    endtask

    task automatic branch(input logic [AW-1:0] a);
        clear_inputs(); BranchEn = 1; LutAddr = a; step();
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [D-1:0] v, input logic ab);
        clear_inputs(); WrEn = 1; WrAddr = a; WrData = v; WrAbs = ab; step();
    endtask

    task automatic goto_pc(input int n);
        clear_inputs(); Start = 1; step();
        for (int k = 0; k < n; k++) idle();
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) begin m_val[i] = '0; m_abs[i] = 0; end
        clear_inputs();
        Reset = 1; step();
        check("rst_pc", ProgCtr, 0);
        check("rst_taken", BranchTaken, 0);
        for (int i = 0; i < 5; i++) begin
            clear_inputs(); LutAddr = AW'(i); step();
            check("idle_pc", ProgCtr, i + 1);
        end

        write(1, 12'd94, 1);
        write(5, 12'hFFB, 0);
        goto_pc(20);
        branch(5);
        check("rel_back", ProgCtr, 15);
        check("rel_taken", BranchTaken, 1);
        branch(1);
        check("abs_pc", ProgCtr, 94);
        idle();
        check("taken_drop", BranchTaken, 0);

        write(2, 12'hFFB, 0);
        goto_pc(3);
        branch(2);
        check("underflow", ProgCtr, 4094);
        idle();
        idle();
        check("inc_wrap", ProgCtr, 0);

        goto_pc(10);
        clear_inputs(); WrEn = 1; WrAddr = 3; WrData = 12'd7; BranchEn = 1; LutAddr = 3; step();
        check("old_entry", ProgCtr, 10);
        branch(3);
        check("new_entry", ProgCtr, 17);

        goto_pc(40);
        branch(7);
        check("oor_hold", ProgCtr, 40);
        check("oor_taken", BranchTaken, 1);
        write(6, 12'd99, 1);
        branch(6);
        check("oor_write", ProgCtr, 41);

        goto_pc(8);
        clear_inputs(); Stall = 1; BranchEn = 1; LutAddr = 1; step();
        check("stall_pc", ProgCtr, 8);
        check("stall_taken", BranchTaken, 0);
        clear_inputs(); Start = 1; BranchEn = 1; LutAddr = 1; step();
        check("start_pc", ProgCtr, 0);
        check("start_taken", BranchTaken, 0);

        goto_pc(5);
        clear_inputs(); Reset = 1; WrEn = 1; WrAddr = 1; WrData = 12'd50; WrAbs = 1; step();
        check("midrst_pc", ProgCtr, 0);
        branch(1);
        check("midrst_tbl1", ProgCtr, 0);
        branch(5);
        check("midrst_tbl5", ProgCtr, 0);

`ifdef PC_LINK_EN
        write(4, 12'd100, 1);
        goto_pc(30);
        clear_inputs(); Call = 1; BranchEn = 1; LutAddr = 4; step();
        check("call_pc", ProgCtr, 100);
        check("call_link", LinkReg, 31);
        idle(); idle(); idle();
        clear_inputs(); Ret = 1; step();
        check("ret_pc", ProgCtr, 31);
        check("ret_taken", BranchTaken, 1);
        clear_inputs(); Call = 1; Ret = 1; BranchEn = 1; LutAddr = 4; step();
        check("callret_link", LinkReg, 31);
        clear_inputs(); Call = 1; step();
        check("call_nobr", LinkReg, 31);
`endif

        for (int n = 0; n < 400; n++) begin
            clear_inputs();
            Reset    = ($urandom_range(0, 49) == 0);
            Start    = ($urandom_range(0, 19) == 0);
            Stall    = ($urandom_range(0, 5) == 0);
            BranchEn = ($urandom_range(0, 2) == 0);
            LutAddr  = AW'($urandom_range(0, 2**AW - 1));
            WrEn     = ($urandom_range(0, 2) == 0);
            WrAddr   = AW'($urandom_range(0, 2**AW - 1));
            WrData   = D'($urandom);
            WrAbs    = 1'($urandom_range(0, 1));
`ifdef PC_LINK_EN
            Call     = 1'($urandom_range(0, 1));
            Ret      = ($urandom_range(0, 7) == 0);
`endif
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
